// File: rtl/config_chain_param.sv
// config_chain_param: serial configuration daisy-chain segment.
// A chain of NODES*GROUPS flops is loaded one bit per enabled clock. A small
// session FSM counts shifts, flags overshift and emits a one-cycle commit when
// a fully loaded chain sees the shift enable drop.
// Optional build macro: CFG_SHADOW_EN -- when defined, cfg_out comes from a
// shadow register that is only updated at commit; when undefined, cfg_out is
// the live chain.
module config_chain_param #(
  parameter int NODES = 13,
  parameter int GROUPS = 8,
  localparam int N = NODES * GROUPS,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prgm_b,
  input  logic          cb_prgm_b,
  input  logic          bit_in,
  output logic          bit_out,
  output logic [N-1:0]  cfg_out,
  output logic [CW-1:0] shift_count,
  output logic          cfg_done,
  output logic          cfg_valid,
  output logic          commit,
  output logic          overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LOADED = 2'd2
  } state_e;

  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(N);

  state_e        state_q, state_d;
  logic [N-1:0]  chain_q, chain_d;
  logic          bit_out_q, bit_out_d;
  logic [CW-1:0] count_q, count_d;
  logic          commit_q, commit_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic          sh_en;

  // The block shifts only when the global strobe is low and this block is selected.
  assign sh_en = ~prgm_b & cb_prgm_b;

  // Chain data path: shift toward the high index on enable, otherwise hold.
  always_comb begin
    chain_d   = chain_q;
    bit_out_d = bit_out_q;
    if (sh_en) begin
      bit_out_d  = chain_q[N-1];
      chain_d[0] = bit_in;
      for (int p = 1; p < N; p++) begin
        chain_d[p] = chain_q[p-1];
      end
    end
  end

  // Session FSM: counts shifts, detects a full load and overshift, commits on enable drop.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    commit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sh_en) begin
          count_d    = COUNT_ONE;
          overflow_d = 1'b0;
          state_d    = (N == 1) ? LOADED : SHIFT;
        end
      end
      SHIFT: begin
        if (sh_en) begin
          count_d = count_q + COUNT_ONE;
          if ((count_q + COUNT_ONE) == COUNT_FULL) begin
            state_d = LOADED;
          end
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      LOADED: begin
        if (sh_en) begin
          overflow_d = 1'b1;
        end else begin
          commit_d = 1'b1;
          valid_d  = 1'b1;
          count_d  = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State and data registers; synchronous reset wins over any shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      chain_q    <= '0;
      bit_out_q  <= 1'b0;
      count_q    <= '0;
      commit_q   <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      chain_q    <= chain_d;
      bit_out_q  <= bit_out_d;
      count_q    <= count_d;
      commit_q   <= commit_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef CFG_SHADOW_EN
  logic [N-1:0] shadow_q, shadow_d;

  // Shadow copy captures the chain exactly on the commit cycle.
  always_comb begin
    shadow_d = shadow_q;
    if (commit_d) begin
      shadow_d = chain_q;
    end
  end

  // Shadow register, cleared with the rest of the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign cfg_out = shadow_q;
`else
  assign cfg_out = chain_q;
`endif

  assign bit_out     = bit_out_q;
  assign shift_count = count_q;
  assign cfg_done    = (state_q == LOADED);
  assign cfg_valid   = valid_q;
  assign commit      = commit_q;
  assign overflow    = overflow_q;

endmodule
